mux2_top: RTL and testbench
===========================

MUX2_TOP -- requirements
Module: mux2_top

Interface
REQ-001 Parameter WIDTH, default 1: data width of mux_in1, mux_in2, mux_out and mux_out_q; legal range 1 to 64.
REQ-002 Parameter CNT_W, default 16: width of sel_switch_cnt; legal range 1 to 32.
REQ-003 Port clk, input, 1 bit: the block's only clock; every register samples on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port mux_in1, input, WIDTH bits: data input selected when mux_sel=1.
REQ-006 Port mux_in2, input, WIDTH bits: data input selected when mux_sel=0.
REQ-007 Port mux_sel, input, 1 bit: select line.
REQ-008 Port mux_out, output, WIDTH bits: combinational selected data.
REQ-009 Port mux_out_q, output, WIDTH bits: registered copy of mux_out.
REQ-010 Port sel_switch_cnt, output, CNT_W bits: count of select transitions; present only when MUX2_SWITCH_CNT_EN is defined.

Function
REQ-011 mux_out SHALL equal mux_in1 when mux_sel=1 and mux_in2 when mux_sel=0, with zero clock latency and no dependence on clk or rst.
REQ-012 mux_out SHALL be X-pessimistic: if mux_sel is X or Z, mux_out is X in simulation, with no silent default to either input.
REQ-013 mux_out_q SHALL load mux_out on each rising clk edge with rst=0, giving exactly one cycle of latency.
REQ-014 The block SHALL keep an internal register sel_q holding mux_sel from the previous cycle.
REQ-015 A switch event is defined as mux_sel differing from sel_q on a rising edge with rst=0.
REQ-016 sel_switch_cnt SHALL increment by 1 on each switch event and saturate at all-ones; it SHALL NOT wrap.
REQ-017 A select change and a data change in the same cycle SHALL both be reflected immediately on mux_out and one cycle later on mux_out_q.

Reset
REQ-018 With rst=1 at a rising edge: mux_out_q, sel_switch_cnt and sel_q SHALL all go to 0.
REQ-019 A reset asserted mid-operation SHALL clear all registered state at the next edge and SHALL NOT affect mux_out.
REQ-020 The first cycle after reset release SHALL count a switch only if mux_sel=1, since sel_q reset value is 0.

Configuration
REQ-021 Macro MUX2_SWITCH_CNT_EN:
- Defined: sel_q, the saturating counter and port sel_switch_cnt are compiled in.
- Undefined: all three are absent, and the port list is exactly clk, rst, mux_in1, mux_in2, mux_sel, mux_out, mux_out_q.

Structure
REQ-022 Package mux2_pkg SHALL hold these defaults as constants: WIDTH 1, CNT_W 16, and the select encodings SEL_IN1=1'b1 and SEL_IN2=1'b0.
REQ-023 The combinational select SHALL be a sub-module mux2_core (ports mux_in1, mux_in2, mux_sel, mux_out) instantiated in mux2_top; all registers live in mux2_top.

Verification
REQ-024 WIDTH=1, the bench drives these cases without a clock; each check is made after a 25 ns settle:
- mux_in1=0, mux_in2=0, mux_sel=1: mux_out=0.
- mux_in1=1, mux_in2=0, mux_sel=1: mux_out=1.
- mux_in1=0, mux_in2=1, mux_sel=1: mux_out=0.
- mux_in1=0, mux_in2=1, mux_sel=0: mux_out=1.
- mux_in1=1, mux_in2=1, mux_sel=1: mux_out=1.
REQ-025 Registered path: after rst=1 for 2 cycles, mux_out_q=0. Then with mux_in1=1 and mux_sel=1, mux_out_q=1 exactly one edge later.
REQ-026 With MUX2_SWITCH_CNT_EN defined, after reset drive mux_sel 0,1,0,1 on consecutive cycles: sel_switch_cnt=3. Then hold mux_sel: the count stays 3.
REQ-027 With CNT_W=2, toggle mux_sel every cycle for 6 cycles: sel_switch_cnt saturates at 3.
REQ-028 Assert rst with sel_switch_cnt=3 and mux_out_q=1: both read 0 after the edge, while mux_out still follows its inputs.
REQ-029 With WIDTH=8, mux_in1=8'hA5, mux_in2=8'h3C: mux_sel=1 gives mux_out=8'hA5 and mux_sel=0 gives mux_out=8'h3C.

Source files
------------

// File: rtl/mux2_pkg.sv
// Shared constants for the two-input mux slice.
// Default widths and select encodings used by mux2_core and mux2_top.
package mux2_pkg;

  localparam int   DEF_WIDTH = 1;
  localparam int   DEF_CNT_W = 16;
  localparam logic SEL_IN1   = 1'b1;
  localparam logic SEL_IN2   = 1'b0;

endpackage

// File: rtl/mux2_core.sv
// Combinational 2:1 select.
// An unknown select drives X so bad selects are never silently masked.
module mux2_core
  import mux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] mux_in1,
  input  logic [WIDTH-1:0] mux_in2,
  input  logic             mux_sel,
  output logic [WIDTH-1:0] mux_out
);

  always_comb begin
    mux_out = 'x;
    case (mux_sel)
      SEL_IN1: mux_out = mux_in1;
      SEL_IN2: mux_out = mux_in2;
    endcase
  end

endmodule

// File: rtl/mux2_top.sv
// 2:1 mux with registered output and optional select-switch counter.
// Define MUX2_SWITCH_CNT_EN to build sel_q and the sel_switch_cnt port.
module mux2_top
  import mux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] mux_in1,
  input  logic [WIDTH-1:0] mux_in2,
  input  logic             mux_sel,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] mux_out_q
`ifdef MUX2_SWITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] sel_switch_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("mux2_top: WIDTH out of range 1..64");
  end

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("mux2_top: CNT_W out of range 1..32");
  end

  mux2_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .mux_in1 (mux_in1),
    .mux_in2 (mux_in2),
    .mux_sel (mux_sel),
    .mux_out (mux_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_out_q <= '0;
    end else begin
      mux_out_q <= mux_out;
    end
  end

`ifdef MUX2_SWITCH_CNT_EN
  logic sel_q;

  // Counter holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q          <= 1'b0;
      sel_switch_cnt <= '0;
    end else begin
      sel_q <= mux_sel;
      if (mux_sel != sel_q && sel_switch_cnt != '1) begin
        sel_switch_cnt <= sel_switch_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux2_top.sv
// Directed self-checking bench for mux2_top.
// Two instances: WIDTH=1/CNT_W=16 and WIDTH=8/CNT_W=2.
module tb_mux2_top;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       a1;
  logic       b1;
  logic       o1;
  logic       q1;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [7:0] o8;
  logic [7:0] q8;

  int checks;
  int errors;

`ifdef MUX2_SWITCH_CNT_EN
  logic [15:0] c1;
  logic [1:0]  c8;
`endif

  mux2_top u1 (
    .clk            (clk),
    .rst            (rst),
    .mux_in1        (a1),
    .mux_in2        (b1),
    .mux_sel        (sel),
    .mux_out        (o1),
    .mux_out_q      (q1)
`ifdef MUX2_SWITCH_CNT_EN
    ,
    .sel_switch_cnt (c1)
`endif
  );

  mux2_top #(
    .WIDTH (8),
    .CNT_W (2)
  ) u8 (
    .clk            (clk),
    .rst            (rst),
    .mux_in1        (a8),
    .mux_in2        (b8),
    .mux_sel        (sel),
    .mux_out        (o8),
    .mux_out_q      (q8)
`ifdef MUX2_SWITCH_CNT_EN
    ,
    .sel_switch_cnt (c8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    sel = 1'b0;
    a1  = 1'b0;
    b1  = 1'b0;
    a8  = 8'h00;
    b8  = 8'h00;

    // combinational vectors, 25 ns settle each
    a1 = 0; b1 = 0; sel = 1; #25;
    check("comb_00_s1", o1, 1'b0);
    a1 = 1; b1 = 0; sel = 1; #25;
    check("comb_10_s1", o1, 1'b1);
    a1 = 0; b1 = 1; sel = 1; #25;
    check("comb_01_s1", o1, 1'b0);
    a1 = 0; b1 = 1; sel = 0; #25;
    check("comb_01_s0", o1, 1'b1);
    a1 = 1; b1 = 1; sel = 1; #25;
    check("comb_11_s1", o1, 1'b1);

    // reset for two edges
    sel = 0; a1 = 0; b1 = 0;
    tick();
    tick();
    check("rst_q1", q1, 1'b0);
    check("rst_q8", q8, 8'h00);
`ifdef MUX2_SWITCH_CNT_EN
    check("rst_cnt1", c1, 16'd0);
`endif

    // first cycle after release with sel=1 counts a switch
    rst = 0; a1 = 1; b1 = 0; sel = 1;
    check("q1_before_edge", q1, 1'b0);
    tick();
    check("q1_one_edge", q1, 1'b1);
`ifdef MUX2_SWITCH_CNT_EN
    check("cnt1_first", c1, 16'd1);
`endif

    // mid-operation reset: registers clear, mux_out unaffected
    rst = 1;
    tick();
    check("midrst_q1", q1, 1'b0);
    check("midrst_o1", o1, 1'b1);
`ifdef MUX2_SWITCH_CNT_EN
    check("midrst_cnt1", c1, 16'd0);
`endif

    // sel sequence 0,1,0,1 -> three switches
    rst = 0;
    sel = 0; tick();
    sel = 1; tick();
    sel = 0; tick();
    sel = 1; tick();
`ifdef MUX2_SWITCH_CNT_EN
    check("cnt1_seq", c1, 16'd3);
    check("cnt8_seq", c8, 2'd3);
`endif
    tick();
    tick();
`ifdef MUX2_SWITCH_CNT_EN
    check("cnt1_hold", c1, 16'd3);
`endif

    // six more toggles: wide counter 9, narrow counter saturated at 3
    for (int i = 0; i < 6; i++) begin
      sel = ~sel;
      tick();
    end
`ifdef MUX2_SWITCH_CNT_EN
    check("cnt1_nine", c1, 16'd9);
    check("cnt8_sat", c8, 2'd3);
`endif
    check("q1_pre_rst", q1, 1'b1);

    // reset with count=3 / q=1; mux_out keeps following inputs
    rst = 1; a1 = 0;
    tick();
    check("rst_q1_clr", q1, 1'b0);
    check("rst_o1_follow0", o1, 1'b0);
`ifdef MUX2_SWITCH_CNT_EN
    check("rst_cnt8_clr", c8, 2'd0);
`endif
    a1 = 1; #1;
    check("rst_o1_follow1", o1, 1'b1);

    // select and data change together
    rst = 0; a1 = 0; b1 = 0; sel = 1;
    tick();
    check("q1_zero", q1, 1'b0);
    sel = 0; b1 = 1; #1;
    check("same_cyc_o1", o1, 1'b1);
    check("same_cyc_q1_old", q1, 1'b0);
    tick();
    check("same_cyc_q1_new", q1, 1'b1);

    // 8-bit data path
    a8 = 8'hA5; b8 = 8'h3C; sel = 1; #1;
    check("w8_sel1", o8, 8'hA5);
    tick();
    check("w8_q_sel1", q8, 8'hA5);
    sel = 0; #1;
    check("w8_sel0", o8, 8'h3C);
    check("w8_q_hold", q8, 8'hA5);
    tick();
    check("w8_q_sel0", q8, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
